count_seq_monitor: RTL and testbench

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

---
 rtl/count_seq_monitor_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/count_seq_monitor.sv | 121 ++++++++++++
 tb/tb_count_seq_monitor.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_monitor_pkg.sv
// Shared definitions for the ripple-counter sequence monitor: FSM states,
// error codes and the default stall limit.
package count_seq_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SKIP  = 2'b01;
  localparam logic [1:0] ERR_STALL = 2'b10;

  localparam int STALL_CYCLES_DEFAULT = 16;

  // True when 'to' is the modulo-4 successor of 'from'.
  function automatic logic is_next(input logic [1:0] from, input logic [1:0] to);
    return to == from + 2'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of slowly changing, gray-like bits.
// Both stages clear on the synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  // NOTE: non-blocking assignments make sync1 -> q a true two-stage shift;
  // blocking ones would collapse both stages into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Monitors a 2-bit upstream ripple counter: locks after four valid increments,
// counts 3->0 wraps while locked, and latches skip/stall errors until cleared.
module count_seq_monitor
  import count_seq_monitor_pkg::*;
#(
  parameter int STALL_CYCLES = STALL_CYCLES_DEFAULT,
  parameter int WRAP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        count_in,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int                 STALL_W    = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  logic [1:0]         sync2;
  logic [1:0]         prev;
  logic               step;
  logic               step_ok;
  state_t             state;
  logic [1:0]         run;
  logic [STALL_W-1:0] stall_cnt;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (count_in),
    .q     (sync2)
  );

  // prev keeps tracking sync2 through clear so no step is lost or invented.
  always_ff @(posedge clk) begin
    if (reset) prev <= 2'd0;
    else       prev <= sync2;
  end

  assign step    = (sync2 != prev);
  assign step_ok = is_next(prev, sync2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      run        <= 2'd0;
      stall_cnt  <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        run        <= 2'd0;
        stall_cnt  <= '0;
        locked     <= 1'b0;
        wrap_count <= '0;
        error      <= 1'b0;
        err_code   <= ERR_NONE;
      end else begin
        case (state)
          IDLE: begin
            if (step && step_ok) begin
              state <= ACQUIRE;
              run   <= 2'd1;
            end
          end
          ACQUIRE: begin
            if (step) begin
              if (!step_ok) begin
                state <= IDLE;
                run   <= 2'd0;
              end else if (run == 2'd3) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                run       <= 2'd0;
                stall_cnt <= '0;
              end else begin
                run <= run + 2'd1;
              end
            end
          end
          LOCKED: begin
            // A step, even an invalid one, pre-empts a same-cycle stall expiry.
            if (step) begin
              stall_cnt <= '0;
              if (!step_ok) begin
                state    <= ERROR;
                locked   <= 1'b0;
                error    <= 1'b1;
                err_code <= ERR_SKIP;
              end else if (prev == 2'd3) begin
                wrap_pulse <= 1'b1;
                wrap_count <= wrap_count + 1'b1;
              end
            end else if (stall_cnt == STALL_LAST) begin
              state    <= ERROR;
              locked   <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_STALL;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
          ERROR: begin
            // Sticky until clear or reset.
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench for count_seq_monitor: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [1:0] count_in;

  logic       locked_a, wrap_pulse_a, error_a;
  logic [7:0] wrap_count_a;
  logic [1:0] err_code_a;
  logic       locked_b, wrap_pulse_b, error_b;
  logic [1:0] wrap_count_b;
  logic [1:0] err_code_b;

  int n_total = 0;
  int n_bad   = 0;
  int cur     = 0;

  always #5 clk = ~clk;

  count_seq_monitor dut_a (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .clear      (clear),
    .locked     (locked_a),
    .wrap_pulse (wrap_pulse_a),
    .wrap_count (wrap_count_a),
    .error      (error_a),
    .err_code   (err_code_a)
  );

  count_seq_monitor #(.WRAP_W(2)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .clear      (clear),
    .locked     (locked_b),
    .wrap_pulse (wrap_pulse_b),
    .wrap_count (wrap_count_b),
    .error      (error_b),
    .err_code   (err_code_b)
  );

  // Behavioural model: a sample delay line, a mode, and plain counters.
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_ERR = 3;
  int m_d1, m_d2, m_pv, m_mode, m_run, m_quiet, m_wraps, m_code;
  bit m_pulse;

  task automatic model_edge();
    int now_v, old_v;
    bit moved, good;
    if (reset) begin
      m_d1 = 0; m_d2 = 0; m_pv = 0; m_mode = M_IDLE; m_run = 0;
      m_quiet = 0; m_wraps = 0; m_code = 0; m_pulse = 0;
      return;
    end
    now_v = m_d2;
    old_v = m_pv;
    m_pv  = m_d2;
    m_d2  = m_d1;
    m_d1  = int'(count_in);
    moved = (now_v != old_v);
    good  = (now_v == (old_v + 1) % 4);
    m_pulse = 0;
    if (clear) begin
      m_mode = M_IDLE; m_run = 0; m_quiet = 0; m_wraps = 0; m_code = 0;
    end else if (m_mode == M_IDLE) begin
      if (moved && good) begin m_mode = M_ACQ; m_run = 1; end
    end else if (m_mode == M_ACQ) begin
      if (moved && !good) begin
        m_mode = M_IDLE; m_run = 0;
      end else if (moved) begin
        m_run++;
        if (m_run == 4) begin m_mode = M_LOCK; m_quiet = 0; end
      end
    end else if (m_mode == M_LOCK) begin
      if (moved && !good) begin
        m_mode = M_ERR; m_code = 1;
      end else if (moved) begin
        m_quiet = 0;
        if (now_v == 0) begin m_pulse = 1; m_wraps++; end
      end else begin
        m_quiet++;
        if (m_quiet >= 16) begin m_mode = M_ERR; m_code = 2; end
      end
    end
  endtask

  function automatic logic [12:0] exp_a();
    return {m_mode == M_LOCK, m_mode == M_ERR, 2'(m_code), m_pulse, 8'(m_wraps % 256)};
  endfunction

  function automatic logic [6:0] exp_b();
    return {m_mode == M_LOCK, m_mode == M_ERR, 2'(m_code), m_pulse, 2'(m_wraps % 4)};
  endfunction

  function automatic logic [12:0] got_a();
    return {locked_a, error_a, err_code_a, wrap_pulse_a, wrap_count_a};
  endfunction

  function automatic logic [6:0] got_b();
    return {locked_b, error_b, err_code_b, wrap_pulse_b, wrap_count_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; count_in = 2'd0;
    tick();
    tick();
    n_total++;
    if (got_a() !== 13'd0 || got_b() !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_values: got %h/%h want 0/0", got_a(), got_b());
    end
    reset = 1'b0;
    cur = 0;
  endtask

  task automatic test_lock_and_wrap();
    int idx = 0, first_lock = -1, pulses = 0;
    for (int s = 1; s <= 12; s++) begin
      cur = s % 4;
      count_in = 2'(cur);
      repeat (10) begin
        tick();
        n_total++;
        if (got_a() !== exp_a() || got_b() !== exp_b()) begin
          n_bad++;
          $display("FAIL lock_wrap cyc%0d: got %h/%h want %h/%h", idx, got_a(), got_b(), exp_a(), exp_b());
        end
        if (locked_a === 1'b1 && first_lock < 0) first_lock = idx;
        if (wrap_pulse_a === 1'b1) pulses++;
        idx++;
      end
    end
    n_total++;
    if (first_lock !== 32 || pulses !== 2 || wrap_count_a !== 8'd2 || locked_a !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_wrap_summary: lock_cyc=%0d pulses=%0d wc=%0d want 32 2 2", first_lock, pulses, wrap_count_a);
    end
  endtask

  task automatic test_skip();
    cur = 1; count_in = 2'd1;
    repeat (10) tick();
    count_in = 2'd3;
    tick();
    tick();
    n_total++;
    if (error_a !== 1'b0 || locked_a !== 1'b1) begin
      n_bad++;
      $display("FAIL skip_early: error=%b locked=%b want 0 1", error_a, locked_a);
    end
    tick();
    n_total++;
    if (error_a !== 1'b1 || err_code_a !== 2'b01 || locked_a !== 1'b0) begin
      n_bad++;
      $display("FAIL skip_detect: error=%b code=%b locked=%b want 1 01 0", error_a, err_code_a, locked_a);
    end
    cur = 3;
    for (int s = 0; s < 6; s++) begin
      cur = (cur + 1) % 4;
      count_in = 2'(cur);
      repeat (5) begin
        tick();
        n_total++;
        if (got_a() !== exp_a() || got_b() !== exp_b()) begin
          n_bad++;
          $display("FAIL skip_sticky: got %h/%h want %h/%h", got_a(), got_b(), exp_a(), exp_b());
        end
      end
    end
    n_total++;
    if (wrap_count_a !== 8'd2 || err_code_a !== 2'b01) begin
      n_bad++;
      $display("FAIL skip_hold: wc=%0d code=%b want 2 01", wrap_count_a, err_code_a);
    end
  endtask

  task automatic test_clear_relock();
    // Step arrives on the same edge as clear; clear must win.
    cur = (cur + 1) % 4; count_in = 2'(cur);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_total++;
    if (got_a() !== 13'd0 || got_b() !== 7'd0) begin
      n_bad++;
      $display("FAIL clear_values: got %h/%h want 0/0", got_a(), got_b());
    end
    for (int s = 0; s < 4; s++) begin
      cur = (cur + 1) % 4;
      count_in = 2'(cur);
      repeat (10) begin
        tick();
        n_total++;
        if (got_a() !== exp_a() || got_b() !== exp_b()) begin
          n_bad++;
          $display("FAIL relock: got %h/%h want %h/%h", got_a(), got_b(), exp_a(), exp_b());
        end
      end
    end
    n_total++;
    if (locked_a !== 1'b1 || error_a !== 1'b0) begin
      n_bad++;
      $display("FAIL relock_state: locked=%b error=%b want 1 0", locked_a, error_a);
    end
  endtask

  task automatic test_stall();
    for (int s = 0; s < 5; s++) begin
      cur = (cur + 1) % 4;
      count_in = 2'(cur);
      repeat (16) begin
        tick();
        n_total++;
        if (got_a() !== exp_a() || got_b() !== exp_b()) begin
          n_bad++;
          $display("FAIL stall_ok: got %h/%h want %h/%h", got_a(), got_b(), exp_a(), exp_b());
        end
      end
    end
    n_total++;
    if (error_a !== 1'b0 || locked_a !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_15: error=%b locked=%b want 0 1", error_a, locked_a);
    end
    repeat (20) begin
      tick();
      n_total++;
      if (got_a() !== exp_a() || got_b() !== exp_b()) begin
        n_bad++;
        $display("FAIL stall_expire: got %h/%h want %h/%h", got_a(), got_b(), exp_a(), exp_b());
      end
    end
    n_total++;
    if (error_a !== 1'b1 || err_code_a !== 2'b10 || locked_a !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_16: error=%b code=%b want 1 10", error_a, err_code_a);
    end
  endtask

  task automatic test_wrap_w2();
    logic [1:0] seen[$];
    logic [1:0] want[5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int s = 0; s < 40 && seen.size() < 5; s++) begin
      cur = (cur + 1) % 4;
      count_in = 2'(cur);
      repeat (6) begin
        tick();
        n_total++;
        if (got_a() !== exp_a() || got_b() !== exp_b()) begin
          n_bad++;
          $display("FAIL wrap_w2: got %h/%h want %h/%h", got_a(), got_b(), exp_a(), exp_b());
        end
        if (wrap_pulse_b === 1'b1) seen.push_back(wrap_count_b);
      end
    end
    n_total++;
    if (seen.size() != 5 || wrap_count_a !== 8'd5) begin
      n_bad++;
      $display("FAIL wrap_w2_count: pulses=%0d wc=%0d want 5 5", seen.size(), wrap_count_a);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_total++;
        if (seen[i] !== want[i]) begin
          n_bad++;
          $display("FAIL wrap_w2_seq[%0d]: got %0d want %0d", i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset and clear together: reset wins, so the synchronizer is cleared too.
    reset = 1'b1; clear = 1'b1;
    tick();
    reset = 1'b0; clear = 1'b0;
    n_total++;
    if (got_a() !== 13'd0 || got_b() !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got %h/%h want 0/0", got_a(), got_b());
    end
    cur = 0;
    for (int s = 0; s < 4; s++) begin
      cur = (cur + 1) % 4;
      count_in = 2'(cur);
      repeat (8) begin
        tick();
        n_total++;
        if (got_a() !== exp_a() || got_b() !== exp_b()) begin
          n_bad++;
          $display("FAIL first_step: got %h/%h want %h/%h", got_a(), got_b(), exp_a(), exp_b());
        end
      end
    end
    n_total++;
    if (locked_a !== 1'b1) begin
      n_bad++;
      $display("FAIL first_step_lock: locked=%b want 1", locked_a);
    end
  endtask

  task automatic test_skip_stall_tie();
    cur = (cur + 1) % 4;
    count_in = 2'(cur);
    repeat (16) tick();
    cur = (cur + 2) % 4;
    count_in = 2'(cur);
    repeat (6) begin
      tick();
      n_total++;
      if (got_a() !== exp_a() || got_b() !== exp_b()) begin
        n_bad++;
        $display("FAIL tie: got %h/%h want %h/%h", got_a(), got_b(), exp_a(), exp_b());
      end
    end
    n_total++;
    if (error_a !== 1'b1 || err_code_a !== 2'b01) begin
      n_bad++;
      $display("FAIL tie_code: error=%b code=%b want 1 01", error_a, err_code_a);
    end
  endtask

  task automatic test_random();
    int cyc = 0, r, hold;
    bit do_clear, do_reset;
    while (cyc < 4000) begin
      r = int'($urandom_range(0, 99));
      if (r < 85)      cur = (cur + 1) % 4;
      else if (r < 95) cur = int'($urandom_range(0, 3));
      hold     = int'($urandom_range(1, 20));
      do_clear = ($urandom_range(0, 99) < 3);
      do_reset = ($urandom_range(0, 99) < 1);
      count_in = 2'(cur);
      for (int k = 0; k < hold; k++) begin
        clear = do_clear && (k == 0);
        reset = do_reset && (k == 0);
        tick();
        n_total++;
        if (got_a() !== exp_a() || got_b() !== exp_b()) begin
          n_bad++;
          $display("FAIL random cyc%0d: got %h/%h want %h/%h", cyc, got_a(), got_b(), exp_a(), exp_b());
        end
        cyc++;
      end
    end
    clear = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_and_wrap();
    test_skip();
    test_clear_relock();
    test_stall();
    test_wrap_w2();
    test_reset_mid();
    test_skip_stall_tie();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
